// File: rtl/stateful_unwind.sv
// stateful_unwind: recovers per-step deltas from an accumulated count stream and checks that they increase by 1 each step.
// Latency: one cycle from an accepted input sample to its delta beat on the output.
// Backpressure: in_ready = !out_valid | out_ready. While a beat is stalled, no input is taken and all state holds.
// Optional: define STATEFUL_UNWIND_ERR_CNT_EN to add the err_cnt port, a saturating count of error beats.
module stateful_unwind #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_cnt,
  input  logic         sync_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_delta,
  output logic         out_err,
  output logic         locked,
  output logic         err_sticky
`ifdef STATEFUL_UNWIND_ERR_CNT_EN
  ,
  output logic [W-1:0] err_cnt
`endif
);

  typedef enum logic [1:0] {S_PRIME, S_SYNC, S_TRACK, S_ERR} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_prev;
  logic [W-1:0] r_expect;
  logic         r_out_valid;
  logic [W-1:0] r_out_delta;
  logic         r_out_err;
  logic         r_err_sticky;

  logic         w_accept;
  logic [W-1:0] w_delta;
  logic         w_emit;
  logic         w_emit_err;
  logic         w_mismatch;
  logic         w_load_expect;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_delta    = in_cnt - r_prev;
  assign out_valid  = r_out_valid;
  assign out_delta  = r_out_delta;
  assign out_err    = r_out_err;
  assign locked     = (r_state == S_TRACK);
  assign err_sticky = r_err_sticky;

  // Next state and beat decision. A sample taken during sync_clr becomes the new priming sample.
  always_comb begin
    w_state_nxt   = r_state;
    w_emit        = 1'b0;
    w_emit_err    = 1'b0;
    w_mismatch    = 1'b0;
    w_load_expect = 1'b0;
    if (sync_clr) begin
      w_state_nxt = w_accept ? S_SYNC : S_PRIME;
    end else if (w_accept) begin
      case (r_state)
        S_PRIME: w_state_nxt = S_SYNC;
        S_SYNC: begin
          w_emit        = 1'b1;
          w_load_expect = 1'b1;
          w_state_nxt   = S_TRACK;
        end
        S_TRACK: begin
          w_emit        = 1'b1;
          w_load_expect = 1'b1;
          w_mismatch    = (w_delta != r_expect);
          w_emit_err    = w_mismatch;
          if (w_mismatch) w_state_nxt = S_ERR;
        end
        S_ERR: begin
          w_emit     = 1'b1;
          w_emit_err = 1'b1;
        end
        default: w_state_nxt = S_PRIME;
      endcase
    end
  end

  // State, previous sample and expected-step registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_PRIME;
      r_prev   <= '0;
      r_expect <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)      r_prev   <= in_cnt;
      if (w_load_expect) r_expect <= w_delta + W'(1);
    end
  end

  // Output beat register: load on emit, drop once the beat is taken; sync_clr never flushes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_delta <= '0;
      r_out_err   <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_delta <= w_delta;
      r_out_err   <= w_emit_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky error flag, cleared only by sync_clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_err_sticky <= 1'b0;
    else if (sync_clr)   r_err_sticky <= 1'b0;
    else if (w_mismatch) r_err_sticky <= 1'b1;
  end

`ifdef STATEFUL_UNWIND_ERR_CNT_EN
  logic [W-1:0] r_err_cnt;
  assign err_cnt = r_err_cnt;

  // Saturating count of error beats; a clear wins over an increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err_cnt <= '0;
    else if (sync_clr)
      r_err_cnt <= '0;
    else if (w_emit && w_emit_err && (r_err_cnt != {W{1'b1}}))
      r_err_cnt <= r_err_cnt + W'(1);
  end
`endif

endmodule

// File: tb/tb_stateful_unwind.sv
// Testbench for stateful_unwind: directed streams and random traffic, checked against a reference model.
// The model predicts each delta beat from the stream rules (last sample, expected step, lost-lock flag).
// Runs with either build of the design, with or without STATEFUL_UNWIND_ERR_CNT_EN.
module tb_stateful_unwind;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_cnt;
  logic       sync_clr;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_delta;
  logic       out_err;
  logic       locked;
  logic       err_sticky;
`ifdef STATEFUL_UNWIND_ERR_CNT_EN
  logic [3:0] err_cnt;
`endif

  stateful_unwind #(.W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cnt     (in_cnt),
    .sync_clr   (sync_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_delta  (out_delta),
    .out_err    (out_err),
    .locked     (locked),
    .err_sticky (err_sticky)
`ifdef STATEFUL_UNWIND_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {int d; int e;} beat_t;
  beat_t q[$];

  // Reference model: last sample seen, whether a step has been learned, and whether lock was lost
  bit m_have_prev, m_have_step, m_lost, m_sticky;
  int m_prev, m_exp, m_errcnt;
  bit last_acc;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void reset_model();
    m_have_prev = 0; m_have_step = 0; m_lost = 0; m_sticky = 0;
    m_prev = 0; m_exp = 0; m_errcnt = 0;
    q.delete();
  endfunction

  function automatic void push_beat(input int d, input int e);
    beat_t b;
    b.d = d; b.e = e;
    q.push_back(b);
    if (e != 0 && m_errcnt < 15) m_errcnt++;
  endfunction

  // One clock cycle: drive, check the outputs at negedge, advance the model, step to posedge+1
  task automatic cyc(input bit v, input int c, input bit r, input bit clr);
    bit acc, cons;
    int d;
    in_valid = v; in_cnt = 4'(c); out_ready = r; sync_clr = clr;
    @(negedge clk);
    chk("out_valid", int'(out_valid), int'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_delta", int'(out_delta), q[0].d);
      chk("out_err", int'(out_err), q[0].e);
    end
    chk("in_ready", int'(in_ready), int'((q.size() == 0) || r));
    chk("locked", int'(locked), int'(m_have_step && !m_lost));
    chk("err_sticky", int'(err_sticky), int'(m_sticky));
`ifdef STATEFUL_UNWIND_ERR_CNT_EN
    chk("err_cnt", int'(err_cnt), m_errcnt);
`endif
    cons = (q.size() > 0) && r;
    acc  = v && ((q.size() == 0) || r);
    last_acc = acc;
    if (cons) void'(q.pop_front());
    if (clr) begin
      if (acc) begin
        m_have_prev = 1;
        m_prev = c & 15;
      end else begin
        m_have_prev = 0;
      end
      m_have_step = 0; m_lost = 0; m_sticky = 0; m_errcnt = 0;
    end else if (acc) begin
      if (!m_have_prev) begin
        m_have_prev = 1;
      end else begin
        d = (c - m_prev) & 15;
        if (!m_have_step) begin
          push_beat(d, 0);
          m_have_step = 1;
          m_exp = (d + 1) & 15;
        end else if (m_lost) begin
          push_beat(d, 1);
        end else begin
          push_beat(d, int'(d != m_exp));
          if (d != m_exp) begin
            m_lost = 1;
            m_sticky = 1;
          end
          m_exp = (d + 1) & 15;
        end
      end
      m_prev = c & 15;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int s[$]);
    foreach (s[i]) cyc(1, s[i], 1, 0);
    cyc(0, 0, 1, 0);
  endtask

  int s1[$] = '{0, 1, 3, 6, 10, 15, 5, 12, 4};
  int s2[$] = '{0, 1, 3, 7, 8, 10};
  int s3[$] = '{9, 8, 8};
  int gen_cnt, gen_step;

  initial begin
    rst = 1'b1; in_valid = 0; in_cnt = 0; sync_clr = 0; out_ready = 1;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_delta", int'(out_delta), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_sticky", int'(err_sticky), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;

    // Clean accumulating stream
    feed(s1);
    chk("t1_locked", int'(locked), 1);
    chk("t1_sticky", int'(err_sticky), 0);

    // Step mismatch, then lock loss persists
    cyc(0, 0, 1, 1);
    feed(s2);
    chk("t2_sticky", int'(err_sticky), 1);
    chk("t2_locked", int'(locked), 0);

    // Wrapping expectation: 15 then 0
    cyc(0, 0, 1, 1);
    feed(s3);
    chk("t3_locked", int'(locked), 1);

    // Stall with a pending beat, then release
    cyc(0, 0, 1, 1);
    cyc(1, 0, 1, 0);
    cyc(1, 1, 0, 0);
    repeat (5) cyc(1, 3, 0, 0);
    cyc(1, 3, 1, 0);
    cyc(1, 6, 1, 0);
    cyc(0, 0, 1, 0);

    // sync_clr while in error, with a sample taken that same cycle
    cyc(0, 0, 1, 1);
    feed('{0, 1, 3, 7});
    cyc(1, 7, 1, 1);
    cyc(1, 8, 1, 0);
    cyc(0, 0, 1, 0);
    chk("t5_sticky", int'(err_sticky), 0);

`ifdef STATEFUL_UNWIND_ERR_CNT_EN
    // Many error beats: counter saturates
    cyc(0, 0, 1, 1);
    feed('{0, 1, 3, 7});
    for (int i = 0; i < 17; i++) cyc(1, i * 3, 1, 0);
    cyc(0, 0, 1, 0);
    chk("t6_err_cnt_sat", int'(err_cnt), 15);
`endif

    // Asynchronous reset with a beat pending
    cyc(0, 0, 1, 1);
    cyc(1, 0, 1, 0);
    cyc(1, 1, 0, 0);
    chk("t6_pending", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_delta", int'(out_delta), 0);
    chk("arst_out_err", int'(out_err), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_err_sticky", int'(err_sticky), 0);
    reset_model();
    in_valid = 0; sync_clr = 0; out_ready = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic: mostly well-formed stream with occasional corruption and clears
    gen_cnt = $urandom_range(0, 15);
    gen_step = $urandom_range(0, 15);
    for (int i = 0; i < 600; i++) begin
      int c;
      c = gen_cnt;
      if ($urandom_range(0, 19) == 0) c = $urandom_range(0, 15);
      cyc(bit'($urandom_range(0, 3) != 0), c, bit'($urandom_range(0, 2) != 0),
          bit'($urandom_range(0, 39) == 0));
      if (last_acc) begin
        gen_cnt = (gen_cnt + gen_step) & 15;
        gen_step = (gen_step + 1) & 15;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
